ram_mover: RTL and testbench

Block-transfer engine that acts as the initiator on a synchronous single-port RAM port: it drives address, write data, write enable and read enable, and captures read data one cycle after issuing a read. Sitting between control logic (CPU register bank or boot sequencer) and one `spram` instance, it performs fill, forward copy and checksum over an address range without CPU involvement.

---
 rtl/ram_if.sv | 14 +
 rtl/ram_mover.sv | 212 +++++++++++++++++++++
 tb/tb_ram_mover.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_if.sv
// Single-port RAM initiator bus: the mover drives address/data/strobes, the RAM returns read data.
interface ram_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  ram_we;
  logic                  ram_re;

  modport master (output ram_addr, ram_din, ram_we, ram_re, input ram_dout);
  modport slave  (input ram_addr, ram_din, ram_we, ram_re, output ram_dout);
endinterface

// File: rtl/ram_mover.sv
// Block-transfer engine (fill / forward copy / checksum) driving one single-port RAM.
// Optional feature macro: RAM_MOVER_SUM_EN enables the SUM op, accumulator and result register.
module ram_mover #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  ram_if.master                 ram
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
`ifdef RAM_MOVER_SUM_EN
  localparam logic [1:0] OP_SUM  = 2'b10;
`endif

`ifdef RAM_MOVER_SUM_EN
  typedef enum logic [2:0] {IDLE, FILL, CRD, CWR, SRD, SACC} state_t;
`else
  typedef enum logic [2:0] {IDLE, FILL, CRD, CWR} state_t;
`endif

  state_t                state_q, state_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [LW-1:0]         len_q, len_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                  fin_q, fin_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
`ifdef RAM_MOVER_SUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
`endif

  // fin_q marks the one spare IDLE cycle before done; start is not accepted then
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    src_d    = src_q;
    dst_d    = dst_q;
    fin_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
`ifdef RAM_MOVER_SUM_EN
    acc_d    = acc_q;
    result_d = result_q;
`endif
    case (state_q)
      IDLE: begin
        if (fin_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (start) begin
          src_d = src;
          dst_d = dst;
          len_d = len;
          cnt_d = '0;
          if (len == '0) begin
            fin_d = 1'b1;
          end else begin
            case (op)
              OP_FILL: begin
                state_d = FILL;
                busy_d  = 1'b1;
                addr_d  = dst;
                din_d   = pattern;
                we_d    = 1'b1;
                cnt_d   = LW'(1);
              end
              OP_COPY: begin
                state_d = CRD;
                busy_d  = 1'b1;
                addr_d  = src;
                re_d    = 1'b1;
              end
`ifdef RAM_MOVER_SUM_EN
              OP_SUM: begin
                state_d = SRD;
                busy_d  = 1'b1;
                addr_d  = src;
                re_d    = 1'b1;
                cnt_d   = LW'(1);
                acc_d   = '0;
              end
`endif
              default: fin_d = 1'b1;
            endcase
          end
        end
      end
      FILL: begin
        if (cnt_q == len_q) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else begin
          addr_d = dst_q + ADDR_WIDTH'(cnt_q);
          we_d   = 1'b1;
          cnt_d  = cnt_q + LW'(1);
        end
      end
      CRD: begin
        state_d = CWR;
        addr_d  = dst_q + ADDR_WIDTH'(cnt_q);
        we_d    = 1'b1;
      end
      CWR: begin
        cnt_d = cnt_q + LW'(1);
        if (cnt_d == len_q) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else begin
          state_d = CRD;
          addr_d  = src_q + ADDR_WIDTH'(cnt_d);
          re_d    = 1'b1;
        end
      end
`ifdef RAM_MOVER_SUM_EN
      SRD: begin
        // read data lags its read edge by one cycle, so nothing is returned yet on the first pass
        if (cnt_q > LW'(1)) acc_d = acc_q + ram.ram_dout;
        if (cnt_q == len_q) begin
          state_d = SACC;
        end else begin
          addr_d = src_q + ADDR_WIDTH'(cnt_q);
          re_d   = 1'b1;
          cnt_d  = cnt_q + LW'(1);
        end
      end
      SACC: begin
        result_d = acc_q + ram.ram_dout;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
`ifdef RAM_MOVER_SUM_EN
      acc_q    <= '0;
      result_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      fin_q    <= fin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      re_q     <= re_d;
`ifdef RAM_MOVER_SUM_EN
      acc_q    <= acc_d;
      result_q <= result_d;
`endif
    end
  end

  // Copy write data is forwarded straight from the RAM output; the select is the registered state.
  assign ram.ram_din  = (state_q == CWR) ? ram.ram_dout : din_q;
  assign ram.ram_addr = addr_q;
  assign ram.ram_we   = we_q;
  assign ram.ram_re   = re_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef RAM_MOVER_SUM_EN
  assign result       = result_q;
`else
  assign result       = '0;
`endif

endmodule

// File: tb/tb_ram_mover.sv
// Directed self-checking bench for ram_mover with a behavioural single-port RAM.
module tb_ram_mover;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done;
  logic [DW-1:0] result;

  ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

  ram_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .pattern(pattern), .busy(busy), .done(done), .result(result),
    .ram(ram_bus.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int cyc = 0;
  int c0 = 0;
  int wr_cyc[$], wr_addr[$], rd_cyc[$];
  int both_cnt = 0;
  int done_hi = 0;
  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model plus bus log; logged edge index is the edge number just reached
  always @(posedge clk) begin
    if (ram_bus.ram_we) begin
      mem[ram_bus.ram_addr] <= ram_bus.ram_din;
      wr_cyc.push_back(cyc + 1);
      wr_addr.push_back(int'(ram_bus.ram_addr));
    end
    if (ram_bus.ram_re) begin
      ram_bus.ram_dout <= mem[ram_bus.ram_addr];
      rd_cyc.push_back(cyc + 1);
    end
    if (ram_bus.ram_we && ram_bus.ram_re) both_cnt <= both_cnt + 1;
  end

  always @(negedge clk) if (done) done_hi <= done_hi + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command; lat = edges from accept to done (-1 on timeout)
  task automatic run(input logic [1:0] o, input int s, input int d, input int l, input int p,
                     input bit intr, output int lat, output bit bsy);
    wr_cyc.delete(); wr_addr.delete(); rd_cyc.delete();
    @(negedge clk);
    op = o; src = AW'(s); dst = AW'(d); len = LW'(l); pattern = DW'(p); start = 1'b1;
    @(negedge clk);
    c0 = cyc; start = 1'b0; lat = -1; bsy = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (done) begin
        lat = cyc - c0;
        break;
      end
      bsy |= busy;
      if (intr && k == 2) begin start = 1'b1; dst = AW'(16'h300); pattern = 16'hFFFF; end
      if (intr && k == 3) start = 1'b0;
      @(negedge clk);
    end
  endtask

  int lat;
  bit bsy;
  int d0;
  int exp_fill_addr[4] = '{32'h3FE, 32'h3FF, 32'h000, 32'h001};

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_addr", 32'(ram_bus.ram_addr), 0);
    check("rst_din", 32'(ram_bus.ram_din), 0);
    check("rst_we_re", {30'd0, ram_bus.ram_we, ram_bus.ram_re}, 0);
    rst = 1'b0;

    // FILL wrapping past the top address
    mem[10'h002] <= 16'h1234;
    run(2'b00, 32'h0, 32'h3FE, 4, 32'hA5A5, 1'b0, lat, bsy);
    check("fill_lat", 32'(lat), 5);
    check("fill_busy", 32'(bsy), 1);
    check("fill_nwr", 32'(wr_cyc.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_cyc.size()) begin
        check("fill_addr", 32'(wr_addr[i]), 32'(exp_fill_addr[i]));
        check("fill_edge", 32'(wr_cyc[i] - c0), 32'(i + 1));
      end
    end
    check("fill_m3fe", 32'(mem[10'h3FE]), 32'hA5A5);
    check("fill_m001", 32'(mem[10'h001]), 32'hA5A5);
    check("fill_m002", 32'(mem[10'h002]), 32'h1234);

    // FILL with a competing start mid-command
    run(2'b00, 32'h0, 32'h200, 6, 32'h5A5A, 1'b1, lat, bsy);
    check("ign_lat", 32'(lat), 7);
    check("ign_nwr", 32'(wr_cyc.size()), 6);
    check("ign_m200", 32'(mem[10'h200]), 32'h5A5A);
    check("ign_m205", 32'(mem[10'h205]), 32'h5A5A);
    check("ign_m300", 32'(mem[10'h300]), 32'h0);

    // COPY
    @(negedge clk);
    mem[10'h010] <= 16'h1111; mem[10'h011] <= 16'h2222; mem[10'h012] <= 16'h3333;
    run(2'b01, 32'h010, 32'h100, 3, 32'h0, 1'b0, lat, bsy);
    check("copy_lat", 32'(lat), 7);
    check("copy_m100", 32'(mem[10'h100]), 32'h1111);
    check("copy_m101", 32'(mem[10'h101]), 32'h2222);
    check("copy_m102", 32'(mem[10'h102]), 32'h3333);
    check("copy_nrd", 32'(rd_cyc.size()), 3);
    check("copy_nwr", 32'(wr_cyc.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rd_cyc.size()) check("copy_rd_edge", 32'(rd_cyc[i] - c0), 32'(2 * i + 1));
      if (i < wr_cyc.size()) check("copy_wr_edge", 32'(wr_cyc[i] - c0), 32'(2 * i + 2));
    end

    // SUM
    @(negedge clk);
    mem[10'h020] <= 16'h0001; mem[10'h021] <= 16'h0002; mem[10'h022] <= 16'hFFFF;
    run(2'b10, 32'h020, 32'h0, 3, 32'h0, 1'b0, lat, bsy);
`ifdef RAM_MOVER_SUM_EN
    check("sum_lat", 32'(lat), 4);
    check("sum_result", 32'(result), 32'h0002);
    check("sum_nrd", 32'(rd_cyc.size()), 3);
`else
    check("sum_lat", 32'(lat), 1);
    check("sum_result", 32'(result), 0);
    check("sum_nrd", 32'(rd_cyc.size()), 0);
`endif

    // len=0 for every op, then reserved op with non-zero len
    for (int o = 0; o < 4; o++) begin
      run(2'(o), 32'h050, 32'h060, (o == 3) ? 5 : 0, 32'hBEEF, 1'b0, lat, bsy);
      check("zero_lat", 32'(lat), 1);
      check("zero_busy", 32'(bsy), 0);
      check("zero_acc", 32'(wr_cyc.size() + rd_cyc.size()), 0);
    end

    // Reset asserted between edges in the middle of a COPY
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mem[10'h040 + i] <= 16'h0100 + 16'(i);
      mem[10'h140 + i] <= 16'h0;
    end
    @(negedge clk);
    op = 2'b01; src = 10'h040; dst = 10'h140; len = 11'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_hi;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_addr", 32'(ram_bus.ram_addr), 0);
    check("mrst_din", 32'(ram_bus.ram_din), 0);
    check("mrst_we_re", {30'd0, ram_bus.ram_we, ram_bus.ram_re}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mrst_nodone", 32'(done_hi - d0), 0);
    check("mrst_m142", 32'(mem[10'h142]), 32'h0102);
    check("mrst_m143", 32'(mem[10'h143]), 32'h0);
    run(2'b01, 32'h040, 32'h140, 8, 32'h0, 1'b0, lat, bsy);
    check("rerun_lat", 32'(lat), 17);
    check("rerun_m143", 32'(mem[10'h143]), 32'h0103);
    check("rerun_m147", 32'(mem[10'h147]), 32'h0107);

    check("we_re_overlap", 32'(both_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
